// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the handshaked ALU pipeline stage.
package alu_pkg;

    localparam logic [2:0] OP_ADDU = 3'b000;
    localparam logic [2:0] OP_ADDS = 3'b001;
    localparam logic [2:0] OP_SUBU = 3'b010;
    localparam logic [2:0] OP_SUBS = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MULU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_shift_mul.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle,
// exactly NUMBITS steps after start, with done_o marking the final step.
module alu_shift_mul
    import alu_pkg::*;
#(
    parameter int NUMBITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [NUMBITS-1:0]     a_i,
    input  logic [NUMBITS-1:0]     b_i,
    output logic                   done_o,
    output logic [2*NUMBITS-1:0]   product_o
);

    localparam int CNTW = $clog2(NUMBITS + 1);

    logic [2*NUMBITS-1:0] mcand_q;
    logic [NUMBITS-1:0]   mplier_q;
    logic [2*NUMBITS-1:0] product_q;
    logic [CNTW-1:0]      cnt_q;
    logic                 active_q;

    // High during the iterating cycle whose edge performs the last step.
    assign done_o    = active_q && (cnt_q == CNTW'(NUMBITS - 1));
    assign product_o = product_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
        end else if (start_i) begin
            mcand_q   <= {{NUMBITS{1'b0}}, a_i};
            mplier_q  <= b_i;
            product_q <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b1;
        end else if (active_q) begin
            if (mplier_q[0]) begin
                product_q <= product_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNTW'(1);
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU stage: single-cycle add/sub/logic ops plus an iterative
// multiply, with a holding output register on a valid/ready channel.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int NUMBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic [2:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow,
    output logic               zero,
    output logic               busy
);

    localparam int MSB = NUMBITS - 1;

    state_e               state_q;
    logic                 out_valid_q;
    logic [NUMBITS-1:0]   result_q;
    logic                 carry_q;
    logic                 ovf_q;
    logic                 zero_q;
    logic                 busy_q;

    logic [NUMBITS:0]     sum_w;
    logic [NUMBITS:0]     diff_w;
    logic [NUMBITS-1:0]   result_d;
    logic                 carry_d;
    logic                 ovf_d;

    logic                 accept;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*NUMBITS-1:0] mul_product;

    // NOTE: in_ready must not look at in_valid, otherwise a source that waits
    // for ready before raising valid forms a combinational loop.
    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MULU);

    assign sum_w  = {1'b0, A} + {1'b0, B};
    assign diff_w = {1'b0, A} - {1'b0, B};

    // NOTE: blocking assignments here; the signed-overflow terms read result_d
    // after it is set earlier in the same pass, and every output gets a
    // default first so no latch is inferred.
    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        unique case (opcode)
            OP_ADDU: begin
                result_d = sum_w[MSB:0];
                carry_d  = sum_w[NUMBITS];
                ovf_d    = sum_w[NUMBITS];
            end
            OP_ADDS: begin
                result_d = sum_w[MSB:0];
                carry_d  = sum_w[NUMBITS];
                ovf_d    = (A[MSB] == B[MSB]) && (result_d[MSB] != A[MSB]);
            end
            OP_SUBU: begin
                result_d = diff_w[MSB:0];
                carry_d  = diff_w[NUMBITS];
                ovf_d    = diff_w[NUMBITS];
            end
            OP_SUBS: begin
                result_d = diff_w[MSB:0];
                carry_d  = diff_w[NUMBITS];
                ovf_d    = (A[MSB] != B[MSB]) && (result_d[MSB] != A[MSB]);
            end
            OP_AND:  result_d = A & B;
            OP_OR:   result_d = A | B;
            OP_XOR:  result_d = A ^ B;
            OP_MULU: result_d = '0;
            default: result_d = '0;
        endcase
    end

    alu_shift_mul #(
        .NUMBITS (NUMBITS)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (A),
        .b_i       (B),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (opcode == OP_MULU) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                        end else begin
                            result_q    <= result_d;
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                            zero_q      <= (result_d == '0);
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Output register is free: entering MUL required it.
                    result_q    <= mul_product[MSB:0];
                    carry_q     <= 1'b0;
                    ovf_q       <= |mul_product[2*NUMBITS-1:NUMBITS];
                    zero_q      <= (mul_product[MSB:0] == '0);
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carryout  = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (NUMBITS=8): directed cases plus random
// traffic scored against an arithmetic reference model with timed expectations.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int N = 8;
    localparam int MUL_BUSY = N + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;
    logic         busy;

    alu_pipe #(.NUMBITS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   now          = 0;
    int   mul_left     = 0;
    logic exp_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int   ua, ub, sa, sb, r;
        exp_t e;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            OP_ADDU: begin r = ua + ub; e.c = (r > 255); e.v = e.c; end
            OP_ADDS: begin r = ua + ub; e.c = (r > 255); e.v = (sa + sb > 127) || (sa + sb < -128); end
            OP_SUBU: begin r = ua - ub; e.c = (ua < ub); e.v = e.c; end
            OP_SUBS: begin r = ua - ub; e.c = (ua < ub); e.v = (sa - sb > 127) || (sa - sb < -128); end
            OP_AND:  r = ua & ub;
            OP_OR:   r = ua | ub;
            OP_XOR:  r = ua ^ ub;
            default: begin r = ua * ub; e.v = (r > 255); end
        endcase
        e.res = r[N-1:0];
        e.z   = (e.res == '0);
        e.due = 0;
        return e;
    endfunction

    task automatic check_outputs();
        exp_ov = (exp_q.size() > 0) && (exp_q[0].due <= now);
        check("out_valid", out_valid, exp_ov);
        check("busy", busy, mul_left != 0);
        if (exp_ov && out_valid) begin
            check("result", result, exp_q[0].res);
            check("carryout", carryout, exp_q[0].c);
            check("overflow", overflow, exp_q[0].v);
            check("zero", zero, exp_q[0].z);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic iv, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic ordy);
        logic exp_ir;
        logic acc;
        exp_t e;
        check_outputs();
        in_valid  = iv;
        opcode    = op;
        A         = a;
        B         = b;
        out_ready = ordy;
        #1;
        exp_ir = (mul_left == 0) && (!exp_ov || ordy);
        check("in_ready", in_ready, exp_ir);
        acc = iv && exp_ir;
        if (exp_ov && ordy) void'(exp_q.pop_front());
        if (acc) begin
            e     = model(op, a, b);
            e.due = now + ((op == OP_MULU) ? MUL_BUSY + 1 : 1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (acc && op == OP_MULU) mul_left = MUL_BUSY;
        else if (mul_left > 0) mul_left--;
        now++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mul_left = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_carryout", carryout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_zero", zero, 0);
        check("rst_busy", busy, 0);
        #1;
        check("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        opcode    = '0;
        @(negedge clk);
        do_reset();

        // Reset with a held result, then reset in the middle of a multiply.
        cycle(1'b1, OP_ADDU, 8'h01, 8'h02, 1'b0);
        cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b0);
        do_reset();
        cycle(1'b1, OP_MULU, 8'h0C, 8'h0B, 1'b1);
        repeat (4) cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b1);
        do_reset();
        repeat (12) cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b1);

        // Add/sub flag corners.
        cycle(1'b1, OP_ADDU, 8'hFF, 8'h01, 1'b1);
        check("addu_res", result, 8'h00);
        check("addu_c", carryout, 1);
        check("addu_v", overflow, 1);
        check("addu_z", zero, 1);
        cycle(1'b1, OP_ADDS, 8'h7F, 8'h01, 1'b1);
        check("adds_res", result, 8'h80);
        check("adds_v", overflow, 1);
        check("adds_c", carryout, 0);
        cycle(1'b1, OP_SUBS, 8'h80, 8'h01, 1'b1);
        check("subs_res", result, 8'h7F);
        check("subs_v", overflow, 1);
        check("subs_c", carryout, 0);
        cycle(1'b1, OP_SUBU, 8'h03, 8'h05, 1'b1);
        check("subu_res", result, 8'hFE);
        check("subu_c", carryout, 1);
        check("subu_v", overflow, 1);
        cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b1);

        // Multiply: busy window, then result.
        cycle(1'b1, OP_MULU, 8'h0C, 8'h0B, 1'b0);
        for (int i = 0; i < MUL_BUSY; i++) begin
            check("mul_busy", busy, 1);
            cycle(1'b1, OP_ADDU, 8'h11, 8'h22, 1'b0);
        end
        check("mul_done_busy", busy, 0);
        check("mul_res", result, 8'h84);
        check("mul_v", overflow, 0);
        cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b1);
        cycle(1'b1, OP_MULU, 8'h20, 8'h10, 1'b1);
        repeat (MUL_BUSY) cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b0);
        check("mul2_res", result, 8'h00);
        check("mul2_v", overflow, 1);
        check("mul2_z", zero, 1);
        cycle(1'b1, OP_MULU, 8'h5A, 8'h00, 1'b1);
        repeat (MUL_BUSY) cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b0);
        check("mulb0_z", zero, 1);
        cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b1);

        // Backpressure, then a new op accepted on the transfer edge.
        cycle(1'b1, OP_XOR, 8'hF0, 8'h0F, 1'b0);
        repeat (3) begin
            check("bp_hold", result, 8'hFF);
            cycle(1'b1, OP_AND, 8'hAA, 8'h55, 1'b0);
        end
        cycle(1'b1, OP_AND, 8'hAA, 8'h55, 1'b1);
        check("and_res", result, 8'h00);
        check("and_z", zero, 1);
        cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b1);

        // Back-to-back throughput.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, OP_ADDU, 8'(i * 16 + 3), 8'(i + 1), 1'b1);
            check("tput_valid", out_valid, 1);
        end
        cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom),
                  8'($urandom), ($urandom_range(3) != 0));
        end
        repeat (MUL_BUSY + 4) cycle(1'b0, OP_ADDU, 8'h00, 8'h00, 1'b1);
        check("drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
